fmac_saddr_filter_multi: RTL

- Parametrised multi-entry source-MAC-address filter for the LMAC receive path.
- Compares each frame's source address against a programmable table of NUM_ENTRIES address/mask entries.
- Issues a one-cycle drop decision plus hit information; supports allow-list and deny-list modes.
- Replaces the single-address multicast source filter in the receive pipeline, at the same position after source-address extraction.

---
 rtl/fmac_saddr_filter_multi_if.sv | 35 +++
 rtl/fmac_saddr_filter_multi.sv | 104 ++++++++++
 2 files changed

// File: rtl/fmac_saddr_filter_multi_if.sv
// Configuration, source-address strobe and decision signals of the
// source-MAC filter.
interface fmac_saddr_filter_multi_if #(
    parameter int IDX_W  = 2,
    parameter int ADDR_W = 48
);
    logic              filter_en;
    logic              filter_mode;
    logic              cfg_wr;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [ADDR_W-1:0] cfg_mask;
    logic              cfg_ent_vld;
    logic [ADDR_W-1:0] mac_saddr;
    logic              mac_saddr_vld;
    logic              saddr_filter_done;
    logic              saddr_filter_drop;
    logic              saddr_filter_hit;
    logic [IDX_W-1:0]  saddr_filter_hit_idx;
    logic              saddr_filter_ovf;

    modport master (
        output filter_en, filter_mode, cfg_wr, cfg_idx, cfg_addr, cfg_mask,
               cfg_ent_vld, mac_saddr, mac_saddr_vld,
        input  saddr_filter_done, saddr_filter_drop, saddr_filter_hit,
               saddr_filter_hit_idx, saddr_filter_ovf
    );

    modport slave (
        input  filter_en, filter_mode, cfg_wr, cfg_idx, cfg_addr, cfg_mask,
               cfg_ent_vld, mac_saddr, mac_saddr_vld,
        output saddr_filter_done, saddr_filter_drop, saddr_filter_hit,
               saddr_filter_hit_idx, saddr_filter_ovf
    );
endinterface

// File: rtl/fmac_saddr_filter_multi.sv
// Multi-entry source-MAC filter: address/mask table compare with a
// fixed three-cycle IDLE/CHK/END decision sequence.
module fmac_saddr_filter_multi #(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = 2,
    parameter int ADDR_W      = 48
) (
    input logic clk,
    input logic rst_,
    fmac_saddr_filter_multi_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CHK  = 3'b010,
        END  = 3'b100
    } state_t;

    state_t state, state_nxt;

    logic [NUM_ENTRIES-1:0]             ent_vld;
    logic [NUM_ENTRIES-1:0][ADDR_W-1:0] ent_addr;
    logic [NUM_ENTRIES-1:0][ADDR_W-1:0] ent_mask;

    logic [NUM_ENTRIES-1:0] match, match_q;
    logic                   en_q, mode_q;
    logic                   hit, drop;
    logic [IDX_W-1:0]       hit_idx;
    logic                   accept;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            ent_vld  <= '0;
            ent_addr <= '0;
            ent_mask <= '0;
        end else if (bus.cfg_wr) begin
            // Indices with no matching entry fall through and are ignored.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (bus.cfg_idx == IDX_W'(i)) begin
                    ent_vld[i]  <= bus.cfg_ent_vld;
                    ent_addr[i] <= bus.cfg_addr;
                    ent_mask[i] <= bus.cfg_mask;
                end
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            match[i] = ent_vld[i] & ~|((bus.mac_saddr ^ ent_addr[i]) & ent_mask[i]);
    end

    always_comb begin
        hit     = |match_q;
        hit_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (match_q[i]) hit_idx = IDX_W'(i);
        drop = en_q & (mode_q ? hit : ~hit);
    end

    always_ff @(posedge clk) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept    = bus.mac_saddr_vld;
                state_nxt = bus.mac_saddr_vld ? CHK : IDLE;
            end
            CHK:     state_nxt = END;
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            match_q                  <= '0;
            en_q                     <= 1'b0;
            mode_q                   <= 1'b0;
            bus.saddr_filter_done    <= 1'b0;
            bus.saddr_filter_drop    <= 1'b0;
            bus.saddr_filter_hit     <= 1'b0;
            bus.saddr_filter_hit_idx <= '0;
            bus.saddr_filter_ovf     <= 1'b0;
        end else begin
            // Snapshot at the strobe edge isolates the result from later cfg changes.
            if (accept) begin
                match_q <= match;
                en_q    <= bus.filter_en;
                mode_q  <= bus.filter_mode;
            end
            bus.saddr_filter_done    <= (state == CHK);
            bus.saddr_filter_drop    <= (state == CHK) & drop;
            bus.saddr_filter_hit     <= (state == CHK) & hit;
            bus.saddr_filter_hit_idx <= (state == CHK) ? hit_idx : '0;
            bus.saddr_filter_ovf     <= bus.mac_saddr_vld & ((state == CHK) | (state == END));
        end
    end
endmodule
